// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if
//  Bundles the hazard controller's pipeline-facing signals.
//  master : pipeline side (drives register numbers / controls, receives enables, flushes and selects)
//  slave  : hazard controller side
//  Ports carried: id_r1/id_r2/id_uses_r1/id_uses_r2, ex_rd/ex_mem_read/ex_r1/ex_r2,
//  mem_rd/mem_reg_write, wb_rd/wb_reg_write, mem_branch_taken ->
//  pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_mem_flush, fwd_a, fwd_b,
//  stall_cycles, flush_count.
interface hazard_control_unit_if;
    logic [4:0]  id_r1;
    logic [4:0]  id_r2;
    logic        id_uses_r1;
    logic        id_uses_r2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic [4:0]  ex_r1;
    logic [4:0]  ex_r2;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        mem_branch_taken;
    logic        pc_enable;
    logic        if_id_enable;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output id_r1, id_r2, id_uses_r1, id_uses_r2, ex_rd, ex_mem_read, ex_r1, ex_r2,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_branch_taken,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_mem_flush,
               fwd_a, fwd_b, stall_cycles, flush_count
    );

    modport slave (
        input  id_r1, id_r2, id_uses_r1, id_uses_r2, ex_rd, ex_mem_read, ex_r1, ex_r2,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_branch_taken,
        output pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_mem_flush,
               fwd_a, fwd_b, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//  Hazard controller for a 5-stage LEGv8 pipeline, next to the ID/EX register.
//  Load-use detection with a configurable stall length, branch-taken flushing from MEM,
//  and EX-stage operand forwarding selects.
//  Ports: clk, reset (synchronous, active-high), hif (hazard_control_unit_if.slave).
//  Parameter LOAD_USE_STALL: stall cycles per load-use hazard, 1..7.
//  Macro HAZARD_PERF_CNT_EN: when defined, stall_cycles / flush_count are saturating
//  perf counters; otherwise both read 0 and no counter flops are built.
//
//  state | meaning
//  RUN   | normal flow; a load-use hazard stalls this cycle
//  STALL | extra load-use stall cycles, cnt_q counts the remaining ones
module hazard_control_unit #(
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_control_unit_if.slave  hif
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALL - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hz;
    logic       stall_active;

    // X31 is the zero register, so it can never carry a load-use dependency.
    assign hz = hif.ex_mem_read && (hif.ex_rd != 5'd31) &&
                ((hif.id_uses_r1 && (hif.id_r1 == hif.ex_rd)) ||
                 (hif.id_uses_r2 && (hif.id_r2 == hif.ex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        stall_active     = 1'b0;
        hif.pc_enable    = 1'b1;
        hif.if_id_enable = 1'b1;
        hif.if_id_flush  = 1'b0;
        hif.id_ex_bubble = 1'b0;
        hif.ex_mem_flush = 1'b0;

        if (reset) begin
            state_d = RUN;
            cnt_d   = 3'd0;
        end else if (hif.mem_branch_taken) begin
            // Wrong-path flush overrides and aborts any load-use stall.
            hif.if_id_flush  = 1'b1;
            hif.id_ex_bubble = 1'b1;
            hif.ex_mem_flush = 1'b1;
            state_d          = RUN;
            cnt_d            = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz) begin
                        stall_active = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            state_d = STALL;
                            cnt_d   = STALL_INIT;
                        end
                    end
                end
                STALL: begin
                    // Hazard inputs are ignored here; the stall length is fixed.
                    stall_active = 1'b1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end

        if (stall_active) begin
            hif.pc_enable    = 1'b0;
            hif.if_id_enable = 1'b0;
            hif.id_ex_bubble = 1'b1;
        end
    end

    // EX/MEM result is newer than MEM/WB, so it is checked first.
    always_comb begin
        hif.fwd_a = 2'b00;
        hif.fwd_b = 2'b00;
        if (!reset) begin
            if (hif.mem_reg_write && (hif.mem_rd != 5'd31) && (hif.mem_rd == hif.ex_r1))
                hif.fwd_a = 2'b01;
            else if (hif.wb_reg_write && (hif.wb_rd != 5'd31) && (hif.wb_rd == hif.ex_r1))
                hif.fwd_a = 2'b10;
            if (hif.mem_reg_write && (hif.mem_rd != 5'd31) && (hif.mem_rd == hif.ex_r2))
                hif.fwd_b = 2'b01;
            else if (hif.wb_reg_write && (hif.wb_rd != 5'd31) && (hif.wb_rd == hif.ex_r2))
                hif.fwd_b = 2'b10;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (reset) begin
            stall_cycles_d = 32'd0;
            flush_count_d  = 32'd0;
        end else begin
            if (stall_active && (stall_cycles_q != 32'hFFFF_FFFF))
                stall_cycles_d = stall_cycles_q + 32'd1;
            if (hif.mem_branch_taken && (flush_count_q != 32'hFFFF_FFFF))
                flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        stall_cycles_q <= stall_cycles_d;
        flush_count_q  <= flush_count_d;
    end

    assign hif.stall_cycles = stall_cycles_q;
    assign hif.flush_count  = flush_count_q;
`else
    assign hif.stall_cycles = 32'd0;
    assign hif.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
//  Drives the same pipeline stimulus into a LOAD_USE_STALL=1 and a LOAD_USE_STALL=3
//  instance; per-step expectations go into a scoreboard queue and are compared mid-cycle.
//  Output vector packing: {pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
//  ex_mem_flush, fwd_a, fwd_b}.
module tb_hazard_control_unit;

    localparam logic [8:0] O_RUN = 9'b1_1_0_0_0_00_00;
    localparam logic [8:0] O_STL = 9'b0_0_0_1_0_00_00;
    localparam logic [8:0] O_FLS = 9'b1_1_1_1_1_00_00;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_STALL1 = 32'd2;
    localparam logic [31:0] EXP_STALL3 = 32'd6;
    localparam logic [31:0] EXP_FLUSH  = 32'd1;
`else
    localparam logic [31:0] EXP_STALL1 = 32'd0;
    localparam logic [31:0] EXP_STALL3 = 32'd0;
    localparam logic [31:0] EXP_FLUSH  = 32'd0;
`endif

    typedef struct {
        string      tag;
        logic [8:0] exp1;
        logic [8:0] exp3;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_r1, id_r2, ex_rd, ex_r1, ex_r2, mem_rd, wb_rd;
    logic id_uses_r1, id_uses_r2, ex_mem_read, mem_reg_write, wb_reg_write, mem_branch_taken;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    hazard_control_unit_if hif1 ();
    hazard_control_unit_if hif3 ();

    hazard_control_unit #(.LOAD_USE_STALL(1)) u_hcu1 (.clk(clk), .reset(reset), .hif(hif1));
    hazard_control_unit #(.LOAD_USE_STALL(3)) u_hcu3 (.clk(clk), .reset(reset), .hif(hif3));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        id_r1 = 5'd0; id_r2 = 5'd0; id_uses_r1 = 1'b0; id_uses_r2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_r1 = 5'd0; ex_r2 = 5'd0;
        mem_rd = 5'd0; mem_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
        mem_branch_taken = 1'b0;
    endtask

    task automatic apply();
        hif1.id_r1 = id_r1; hif1.id_r2 = id_r2; hif1.id_uses_r1 = id_uses_r1;
        hif1.id_uses_r2 = id_uses_r2; hif1.ex_rd = ex_rd; hif1.ex_mem_read = ex_mem_read;
        hif1.ex_r1 = ex_r1; hif1.ex_r2 = ex_r2; hif1.mem_rd = mem_rd;
        hif1.mem_reg_write = mem_reg_write; hif1.wb_rd = wb_rd;
        hif1.wb_reg_write = wb_reg_write; hif1.mem_branch_taken = mem_branch_taken;
        hif3.id_r1 = id_r1; hif3.id_r2 = id_r2; hif3.id_uses_r1 = id_uses_r1;
        hif3.id_uses_r2 = id_uses_r2; hif3.ex_rd = ex_rd; hif3.ex_mem_read = ex_mem_read;
        hif3.ex_r1 = ex_r1; hif3.ex_r2 = ex_r2; hif3.mem_rd = mem_rd;
        hif3.mem_reg_write = mem_reg_write; hif3.wb_rd = wb_rd;
        hif3.wb_reg_write = wb_reg_write; hif3.mem_branch_taken = mem_branch_taken;
    endtask

    // One cycle: drive inputs, queue the expectation, compare at the falling edge.
    task automatic step(input string tag, input logic [8:0] e1, input logic [8:0] e3);
        exp_t e;
        logic [8:0] obs1, obs3;
        apply();
        e.tag = tag; e.exp1 = e1; e.exp3 = e3;
        sb_q.push_back(e);
        @(negedge clk);
        obs1 = {hif1.pc_enable, hif1.if_id_enable, hif1.if_id_flush, hif1.id_ex_bubble,
                hif1.ex_mem_flush, hif1.fwd_a, hif1.fwd_b};
        obs3 = {hif3.pc_enable, hif3.if_id_enable, hif3.if_id_flush, hif3.id_ex_bubble,
                hif3.ex_mem_flush, hif3.fwd_a, hif3.fwd_b};
        e = sb_q.pop_front();
        check_eq({e.tag, "/u1"}, 32'(obs1), 32'(e.exp1));
        check_eq({e.tag, "/u3"}, 32'(obs3), 32'(e.exp3));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 5'd31 && mem_rd == src) return 2'b01;
        if (wb_reg_write && wb_rd != 5'd31 && wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 2))
            0:       return 5'd3;
            1:       return 5'd5;
            default: return 5'd31;
        endcase
    endfunction

    task automatic load_use_r1();
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_r1 = 5'd3; id_uses_r1 = 1'b1;
    endtask

    initial begin
        logic [8:0] e;
        clear_inputs();
        reset = 1'b1;
        // Forwarding match present but reset must hold fwd at 00.
        mem_reg_write = 1'b1; mem_rd = 5'd4; ex_r1 = 5'd4;
        step("reset", O_RUN, O_RUN);
        step("reset2", O_RUN, O_RUN);
        reset = 1'b0;
        clear_inputs();
        step("idle", O_RUN, O_RUN);
        check_eq("stall_cnt_rst", hif1.stall_cycles, 32'd0);
        check_eq("flush_cnt_rst", hif1.flush_count, 32'd0);

        // Load-use: 1 stall vs 3 stalls, the latter continuing after ex_mem_read drops.
        load_use_r1();
        step("lu_c1", O_STL, O_STL);
        ex_mem_read = 1'b0;
        step("lu_c2", O_RUN, O_STL);
        step("lu_c3", O_RUN, O_STL);
        step("lu_done", O_RUN, O_RUN);

        // r2 match but not used: no hazard.
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_r2 = 5'd7; id_uses_r2 = 1'b0;
        step("r2_unused", O_RUN, O_RUN);

        // X31 never hazards; EX/MEM beats MEM/WB for fwd_a.
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd31; id_r2 = 5'd31; id_uses_r2 = 1'b1;
        mem_rd = 5'd5; wb_rd = 5'd5; ex_r1 = 5'd5; ex_r2 = 5'd9;
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        step("x31_fwd_a01", O_RUN | 9'b0_0_0_0_0_01_00, O_RUN | 9'b0_0_0_0_0_01_00);
        // X31 not forwarded on a; MEM/WB forwarded on b.
        clear_inputs();
        mem_rd = 5'd31; mem_reg_write = 1'b1; ex_r1 = 5'd31;
        wb_rd = 5'd9; wb_reg_write = 1'b1; ex_r2 = 5'd9;
        step("fwd_b10", O_RUN | 9'b0_0_0_0_0_00_10, O_RUN | 9'b0_0_0_0_0_00_10);

        // Branch taken in cycle 2 of the 3-cycle stall aborts it.
        load_use_r1();
        step("br_c1", O_STL, O_STL);
        clear_inputs();
        mem_branch_taken = 1'b1;
        step("br_c2", O_FLS, O_FLS);
        clear_inputs();
        step("br_after", O_RUN, O_RUN);

        // Branch and hazard together: flush wins, no stall follows.
        load_use_r1();
        mem_branch_taken = 1'b1;
        step("br_hz", O_FLS, O_FLS);
        clear_inputs();
        step("br_hz_after", O_RUN, O_RUN);

        // Reset during stall ends it.
        load_use_r1();
        step("rs_c1", O_STL, O_STL);
        reset = 1'b1;
        step("rs_hold", O_RUN, O_RUN);
        reset = 1'b0;
        clear_inputs();
        step("rs_after", O_RUN, O_RUN);
        check_eq("stall_cnt_after_rst1", hif1.stall_cycles, 32'd0);
        check_eq("stall_cnt_after_rst3", hif3.stall_cycles, 32'd0);
        check_eq("flush_cnt_after_rst", hif1.flush_count, 32'd0);

        // Perf counters: two hazards, one branch.
        load_use_r1();
        step("pc_h1", O_STL, O_STL);
        clear_inputs();
        step("pc_h1b", O_RUN, O_STL);
        step("pc_h1c", O_RUN, O_STL);
        load_use_r1();
        step("pc_h2", O_STL, O_STL);
        clear_inputs();
        step("pc_h2b", O_RUN, O_STL);
        step("pc_h2c", O_RUN, O_STL);
        mem_branch_taken = 1'b1;
        step("pc_br", O_FLS, O_FLS);
        clear_inputs();
        step("pc_end", O_RUN, O_RUN);
        check_eq("stall_cycles_u1", hif1.stall_cycles, EXP_STALL1);
        check_eq("stall_cycles_u3", hif3.stall_cycles, EXP_STALL3);
        check_eq("flush_count_u1", hif1.flush_count, EXP_FLUSH);
        check_eq("flush_count_u3", hif3.flush_count, EXP_FLUSH);

        // Random forwarding patterns, no hazards.
        for (int i = 0; i < 24; i++) begin
            clear_inputs();
            ex_r1 = pick_reg(); ex_r2 = pick_reg();
            mem_rd = pick_reg(); wb_rd = pick_reg();
            mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write  = 1'($urandom_range(0, 1));
            e = O_RUN | {5'b0, fwd_ref(ex_r1), fwd_ref(ex_r2)};
            step("fwd_rand", e, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
